// File: rtl/uart_dbg_bridge.sv
// Host UART debug bridge: pops command bytes, drives SRAM reads/writes,
// holds the CPU in reset while the host owns memory, replies over UART.
// Ports: clk/rst (sync, active-high); rx_rd/rx_d_valid/rx_rdata (RX FIFO);
//   tx_wr/tx_wdata/tx_tbr_valid (transmitter); mem_addr/mem_wdata/mem_wr/
//   mem_rdata (SRAM, 1-cycle read latency); cpu_hold (CPU held in reset).
// Build option: DBG_BRIDGE_CKSUM_EN adds a trailing XOR checksum byte to W/R.
module uart_dbg_bridge #(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rx_rd,
  input  logic                  rx_d_valid,
  input  logic [7:0]            rx_rdata,
  output logic                  tx_wr,
  output logic [7:0]            tx_wdata,
  input  logic                  tx_tbr_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_AH   = 4'd1;
  localparam logic [3:0] S_GET_AL   = 4'd2;
  localparam logic [3:0] S_GET_DH   = 4'd3;
  localparam logic [3:0] S_GET_DL   = 4'd4;
  localparam logic [3:0] S_GET_CK   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_RD_WAIT  = 4'd8;
  localparam logic [3:0] S_SEND_HI  = 4'd9;
  localparam logic [3:0] S_SEND_LO  = 4'd10;
  localparam logic [3:0] S_SEND_ACK = 4'd11;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic [3:0]            state_q, state_d;
  logic                  rx_rd_q, rx_rd_d;
  logic                  tx_wr_q, tx_wr_d;
  logic [7:0]            tx_wdata_q, tx_wdata_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  hold_q, hold_d;
  logic [7:0]            ah_q, ah_d;
  logic [7:0]            dh_q, dh_d;
  logic                  wr_op_q, wr_op_d;
  logic                  ok_q, ok_d;
  logic [7:0]            csum_q, csum_d;
  logic [15:0]           rd_q, rd_d;
  logic [7:0]            resp_q, resp_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  // A byte is taken only when no pop is already in flight, so the FIFO
  // head seen here is never the one being popped this cycle.
  logic take, can_tx, in_get;
  assign take   = rx_d_valid && !rx_rd_q;
  // The cycle after a load, tx_tbr_valid has not yet risen.
  assign can_tx = !tx_tbr_valid && !tx_wr_q;
  assign in_get = (state_q >= S_GET_AH) && (state_q <= S_GET_CK);

  always_comb begin
    state_d     = state_q;
    rx_rd_d     = 1'b0;
    tx_wr_d     = 1'b0;
    tx_wdata_d  = tx_wdata_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    ah_d        = ah_q;
    dh_d        = dh_q;
    wr_op_d     = wr_op_q;
    ok_d        = ok_q;
    csum_d      = csum_q;
    rd_d        = rd_q;
    resp_d      = resp_q;
    tmo_d       = '0;

    if (in_get) begin
      if (take) begin
        rx_rd_d = 1'b1;
        csum_d  = csum_q ^ rx_rdata;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: if (take) begin
        rx_rd_d = 1'b1;
        csum_d  = rx_rdata;
        ok_d    = 1'b1;
        wr_op_d = (rx_rdata == 8'h57);
        resp_d  = ACK;
        state_d = S_SEND_ACK;
        case (rx_rdata)
          8'h48:        hold_d  = 1'b1;
          8'h47:        hold_d  = 1'b0;
          8'h57, 8'h52: state_d = S_GET_AH;
          default:      resp_d  = NAK;
        endcase
      end
      S_GET_AH: if (take) begin
        ah_d    = rx_rdata;
        state_d = S_GET_AL;
      end
      S_GET_AL: if (take) begin
        mem_addr_d = ADDR_WIDTH'({ah_q, rx_rdata});
`ifdef DBG_BRIDGE_CKSUM_EN
        state_d = wr_op_q ? S_GET_DH : S_GET_CK;
`else
        state_d = wr_op_q ? S_GET_DH : S_MEM_RD;
`endif
      end
      S_GET_DH: if (take) begin
        dh_d    = rx_rdata;
        state_d = S_GET_DL;
      end
      S_GET_DL: if (take) begin
        mem_wdata_d = DATA_WIDTH'({dh_q, rx_rdata});
`ifdef DBG_BRIDGE_CKSUM_EN
        state_d = S_GET_CK;
`else
        state_d = S_MEM_WR;
`endif
      end
      S_GET_CK: if (take) begin
        ok_d    = (rx_rdata == csum_q);
        state_d = wr_op_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_wr_d = hold_q && ok_q;
        resp_d   = (hold_q && ok_q) ? ACK : NAK;
        state_d  = S_SEND_ACK;
      end
      S_MEM_RD: begin
        resp_d  = NAK;
        state_d = (hold_q && ok_q) ? S_RD_WAIT : S_SEND_ACK;
      end
      S_RD_WAIT: begin
        rd_d    = 16'(mem_rdata);
        state_d = S_SEND_HI;
      end
      S_SEND_HI: if (can_tx) begin
        tx_wr_d    = 1'b1;
        tx_wdata_d = rd_q[15:8];
        state_d    = S_SEND_LO;
      end
      S_SEND_LO: if (can_tx) begin
        tx_wr_d    = 1'b1;
        tx_wdata_d = rd_q[7:0];
        state_d    = S_IDLE;
      end
      S_SEND_ACK: if (can_tx) begin
        tx_wr_d    = 1'b1;
        tx_wdata_d = resp_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_rd_q     <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_wdata_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b0;
      ah_q        <= '0;
      dh_q        <= '0;
      wr_op_q     <= 1'b0;
      ok_q        <= 1'b0;
      csum_q      <= '0;
      rd_q        <= '0;
      resp_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_rd_q     <= rx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_wdata_q  <= tx_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      ah_q        <= ah_d;
      dh_q        <= dh_d;
      wr_op_q     <= wr_op_d;
      ok_q        <= ok_d;
      csum_q      <= csum_d;
      rd_q        <= rd_d;
      resp_q      <= resp_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_rd     = rx_rd_q;
  assign tx_wr     = tx_wr_q;
  assign tx_wdata  = tx_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: RX FIFO, transmitter and SRAM models plus a
// command-level reference model of replies, writes and cpu_hold.
module tb_uart_dbg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rd, rx_d_valid = 1'b0;
  logic [7:0]  rx_rdata = 8'h00;
  logic        tx_wr;
  logic [7:0]  tx_wdata;
  logic        tx_tbr_valid;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic [15:0] mem_rdata = 16'h0;
  logic        cpu_hold;

  uart_dbg_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .rx_rd(rx_rd), .rx_d_valid(rx_d_valid), .rx_rdata(rx_rdata),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_tbr_valid(tx_tbr_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  logic [28:0] exp_wr[$];
  logic [7:0]  tx_log[$];
  logic [15:0] sram [0:8191];
  logic [15:0] mdl_mem [0:8191];
  bit          mdl_hold = 1'b0;
  int          wr_count = 0;
  logic [12:0] lw_addr = '0;
  logic [15:0] lw_data = '0;
  int          busy = 0;
  bit          force_busy = 1'b0;
  bit          prev_rx_rd = 1'b0;
  int          tx_seen = 0;

  assign tx_tbr_valid = force_busy || (busy != 0);

  // Transmitter: stays occupied for a few cycles after each load.
  always @(posedge clk) begin
    if (tx_wr) busy <= 4;
    else if (busy > 0) busy <= busy - 1;
  end

  // RX FIFO: pop on the strobe, present the head from the falling edge.
  always @(posedge clk) if (rx_rd && rxq.size() != 0) void'(rxq.pop_front());
  always @(negedge clk) begin
    rx_d_valid = (rxq.size() != 0);
    rx_rdata   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of the DUT against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_wr) begin
        tx_seen++;
        tx_log.push_back(tx_wdata);
        tests++;
        if (exp_tx.size() == 0) begin
          fails++;
          $display("FAIL tx_unexpected: got %0h expected none", tx_wdata);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_wdata !== e) begin
            fails++;
            $display("FAIL tx_byte: got %0h expected %0h", tx_wdata, e);
          end
        end
        tests++;
        if (tx_tbr_valid) begin
          fails++;
          $display("FAIL tx_while_busy: got tbr=1 expected tbr=0");
        end
      end
      if (mem_wr) begin
        wr_count++;
        lw_addr = mem_addr;
        lw_data = mem_wdata;
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL mem_wr_unexpected: got %0h/%0h expected none",
                   mem_addr, mem_wdata);
        end else begin
          logic [28:0] e;
          e = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            fails++;
            $display("FAIL mem_wr: got %0h/%0h expected %0h/%0h",
                     mem_addr, mem_wdata, e[28:16], e[15:0]);
          end
        end
      end
      if (rx_rd && prev_rx_rd) begin
        tests++;
        fails++;
        $display("FAIL rx_rd_back_to_back: got 1 expected 0");
      end
    end
    prev_rx_rd = rx_rd;
  end

  // Command-level model: what the host must see for one complete command.
  task automatic do_cmd(input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] d);
    logic [7:0] ck;
    rxq.push_back(op);
    ck = op;
    if (op == 8'h57 || op == 8'h52) begin
      rxq.push_back(a[15:8]);
      rxq.push_back(a[7:0]);
      ck = ck ^ a[15:8] ^ a[7:0];
      if (op == 8'h57) begin
        rxq.push_back(d[15:8]);
        rxq.push_back(d[7:0]);
        ck = ck ^ d[15:8] ^ d[7:0];
      end
`ifdef DBG_BRIDGE_CKSUM_EN
      rxq.push_back(ck);
`endif
      if (!mdl_hold) exp_tx.push_back(8'h15);
      else if (op == 8'h57) begin
        exp_wr.push_back({a[12:0], d});
        mdl_mem[a[12:0]] = d;
        exp_tx.push_back(8'h06);
      end else begin
        exp_tx.push_back(mdl_mem[a[12:0]][15:8]);
        exp_tx.push_back(mdl_mem[a[12:0]][7:0]);
      end
    end else if (op == 8'h48) begin
      mdl_hold = 1'b1;
      exp_tx.push_back(8'h06);
    end else if (op == 8'h47) begin
      mdl_hold = 1'b0;
      exp_tx.push_back(8'h06);
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || rxq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk({name, "_done"}, n < 3000, 1);
    chk({name, "_wr_left"}, exp_wr.size(), 0);
    chk({name, "_hold"}, cpu_hold, mdl_hold);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      sram[i]    = 16'h0;
      mdl_mem[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {rx_rd, tx_wr, tx_wdata, mem_wr, mem_addr, mem_wdata, cpu_hold}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: hold, then write 0xBEEF to 0x0010
    do_cmd(8'h48, 16'h0, 16'h0);
    do_cmd(8'h57, 16'h0010, 16'hBEEF);
    wait_idle("t1");
    chk("t1_hold_lit", cpu_hold, 1);
    chk("t1_wr_count", wr_count, 1);
    chk("t1_wr_addr", lw_addr, 13'h0010);
    chk("t1_wr_data", lw_data, 16'hBEEF);

    // 2: two reads queued back to back
    do_cmd(8'h52, 16'h0010, 16'h0);
    do_cmd(8'h52, 16'h0011, 16'h0);
    wait_idle("t2");
    chk("t2_hi", tx_log[tx_log.size()-4], 8'hBE);
    chk("t2_lo", tx_log[tx_log.size()-3], 8'hEF);
    chk("t2_no_wr", wr_count, 1);

    // 3: address wrap, read it back, release
    do_cmd(8'h57, 16'hFFFF, 16'h1234);
    wait_idle("t3w");
    chk("t3_wrap_addr", lw_addr, 13'h1FFF);
    do_cmd(8'h52, 16'h1FFF, 16'h0);
    do_cmd(8'h47, 16'h0, 16'h0);
    wait_idle("t3");
    chk("t3_rd_hi", tx_log[tx_log.size()-3], 8'h12);
    chk("t3_g_ack", tx_log[tx_log.size()-1], 8'h06);
    chk("t3_hold_lit", cpu_hold, 0);

    // 4: write without hold, bad opcode
    do_cmd(8'h57, 16'h0001, 16'h0001);
    do_cmd(8'h00, 16'h0, 16'h0);
    wait_idle("t4");
    chk("t4_nak1", tx_log[tx_log.size()-2], 8'h15);
    chk("t4_nak2", tx_log[tx_log.size()-1], 8'h15);
    chk("t4_no_wr", wr_count, 2);

    // 5: stalled command is dropped silently
    do_cmd(8'h48, 16'h0, 16'h0);
    wait_idle("t5h");
    tx_seen = 0;
    rxq.push_back(8'h57);
    rxq.push_back(8'h00);
    repeat (60) @(negedge clk);
    chk("t5_silent", tx_seen, 0);
    do_cmd(8'h48, 16'h0, 16'h0);
    wait_idle("t5");
    chk("t5_h_ack", tx_log[tx_log.size()-1], 8'h06);
    chk("t5_no_wr", wr_count, 2);

    // 6: transmitter busy for 100 cycles during a read reply
    force_busy = 1'b1;
    tx_seen = 0;
    do_cmd(8'h52, 16'h0010, 16'h0);
    repeat (100) @(negedge clk);
    chk("t6_no_tx_busy", tx_seen, 0);
    force_busy = 1'b0;
    wait_idle("t6");
    chk("t6_hi", tx_log[tx_log.size()-2], 8'hBE);
    chk("t6_lo", tx_log[tx_log.size()-1], 8'hEF);

    // 6b: reset in the middle of a write
    rxq.push_back(8'h57);
    rxq.push_back(8'h00);
    rxq.push_back(8'h10);
    rxq.push_back(8'hAB);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs",
        {rx_rd, tx_wr, tx_wdata, mem_wr, mem_addr, mem_wdata, cpu_hold}, 0);
    rxq.delete();
    mdl_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_cmd(8'h52, 16'h0010, 16'h0);
    wait_idle("t6r");
    chk("t6_rd_nak", tx_log[tx_log.size()-1], 8'h15);
    chk("t6_no_wr", wr_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
